ram_reader: RTL and testbench
=============================

Name: ram_reader

Overview:
- Read-back counterpart of the team's RAM write sequencer.
- Sweeps a RAM address range with single-cycle read strobes and captures the 64-bit read data after a fixed read latency.
- Checks each word against the incrementing pattern the writer stores, then reports pass/fail, error count and first failing address.
- Sits between the RAM read port and the test/status logic; one read outstanding at a time.

Parameters:
- ADDR_W, 14, RAM address width.
- DATA_W, 64, read data width; four 16-bit lanes.
- RD_LATENCY, 2, cycles from o_rd_en high to i_rd_data valid; legal range 1..7.
- START_ADDR, 1, first address read.
- END_ADDR, 14'h2000, last address read (inclusive).

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_start  in  1  one-cycle pulse; begins a sweep when idle or done.
- o_rd_en  out  1  read strobe, one cycle per address.
- o_rd_addr  out  ADDR_W  read address, valid while o_rd_en=1.
- i_rd_data  in  DATA_W  RAM read data, valid RD_LATENCY cycles after o_rd_en.
- o_busy  out  1  high from the cycle after accepted i_start until sweep end.
- o_done  out  1  high after the last check, held until next accepted i_start or reset.
- o_err  out  1  sticky; set on any mismatch in the current sweep.
- o_err_count  out  16  number of mismatching words, saturates at 16'hFFFF.
- o_first_err_addr  out  ADDR_W  address of first mismatch; 0 if none.

Behaviour:
- Reset (i_rst_n=0 at an edge) sets state IDLE and all outputs to 0, including o_rd_addr. Reset is honoured in any state, mid-sweep included; a pending read is abandoned.
- Expected word for address a, with 16-bit wrap per lane:
  - lane0 [15:0] = 4a
  - lane1 [31:16] = 4a+1
  - lane2 [47:32] = 4a+2
  - lane3 [63:48] = 4a+3
  - a zero-extended to 16 bits before the multiply.
- FSM states:
  - IDLE: i_start -> ISSUE with addr=START_ADDR, err/err_count/first_err_addr cleared, o_busy=1.
  - ISSUE: o_rd_en=1 for exactly one cycle with o_rd_addr=addr; wait counter cleared; -> WAIT.
  - WAIT: counter increments each cycle. When counter reaches RD_LATENCY-1, i_rd_data is sampled at that edge (exactly RD_LATENCY cycles after the ISSUE cycle) and compared -> CHECK.
  - CHECK: apply the compare result. Mismatch: err_count+1 (saturating), o_err=1, first_err_addr=addr if it is the first error. If addr==END_ADDR -> DONE, else addr+1 -> ISSUE.
  - DONE: o_busy=0, o_done=1; i_start -> ISSUE (same clearing as from IDLE, o_done drops).
- Throughput: one address per RD_LATENCY+2 cycles. o_rd_addr holds its last value between strobes.
- i_start while busy is ignored; the sweep is not restarted.
- START_ADDR==END_ADDR: exactly one read.
- Address counter is ADDR_W wide; END_ADDR must be >= START_ADDR. No wrap occurs within a legal sweep.
- A mismatch is any bit difference in any lane; one word counts as one error regardless of lanes hit.

Decomposition:
- Shared package ramrw_pkg holds:
  - state encoding constants (IDLE, ISSUE, WAIT, CHECK, DONE)
  - default ADDR_W and DATA_W
  - the expected-pattern function (address -> 64-bit word); the writer uses the same function to generate data
- Sub-module ram_rd_checker: registered compare plus error counter with saturation, first-error capture and clear input. Everything else stays in ram_reader.

Test Plan:
- RAM model (latency 2) prefilled with the correct pattern, START_ADDR=1, END_ADDR=8, pulse i_start -> 8 single-cycle o_rd_en at addr 1..8, 4 cycles apart; o_done=1, o_err=0, o_err_count=0. First data compared at addr 1 = 64'h0007_0006_0005_0004.
- Same run with lane2 at addr 5 corrupted to 16'h0000 -> o_err=1, o_err_count=1, o_first_err_addr=5.
- Corrupt addr 3 and addr 6 -> o_err_count=2, o_first_err_addr=3. Pulse i_start again with a clean RAM -> counters cleared, o_err=0 at end.
- i_start pulsed at the 3rd o_rd_en of a sweep -> no restart; addresses continue in sequence; single o_done.
- i_rst_n low for one cycle during WAIT of addr 4 -> next cycle all outputs 0 and state IDLE; new i_start begins again at addr 1.
- RD_LATENCY=1 and START_ADDR=END_ADDR=14'h2000 -> one strobe; data sampled 1 cycle later; expected lane0=16'h8000, lane3=16'h8003; o_done set.

Source files
------------

// File: rtl/ramrw_pkg.sv
// Shared definitions for the RAM write/read sequencer pair.
// Holds the sequencer state encoding, the default bus widths and the
// address -> data pattern function that the writer stores and the reader
// checks against.
package ramrw_pkg;

  localparam int unsigned DEF_ADDR_W = 14;
  localparam int unsigned DEF_DATA_W = 64;
  localparam int unsigned LANE_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Four 16-bit lanes holding 4a, 4a+1, 4a+2, 4a+3 (each wrapping at 16 bits).
  function automatic logic [63:0] pattern_word(input logic [LANE_W-1:0] addr16);
    logic [LANE_W-1:0] base;
    base = addr16 << 2;
    return {LANE_W'(base + 16'd3), LANE_W'(base + 16'd2),
            LANE_W'(base + 16'd1), base};
  endfunction

endpackage

// File: rtl/ram_rd_checker.sv
// Registered data check for the RAM reader.
// Ports:
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   i_clear            clears error state at the start of a sweep
//   i_sample           capture compare of i_rd_data against pattern(i_addr)
//   i_apply            fold the captured compare into the error state
//   i_addr, i_rd_data  address being checked and its read data
//   o_err              sticky mismatch flag
//   o_err_count        mismatching words, saturating
//   o_first_err_addr   address of the first mismatch, 0 if none
module ram_rd_checker
  import ramrw_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_sample,
  input  logic              i_apply,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_err,
  output logic [15:0]       o_err_count,
  output logic [ADDR_W-1:0] o_first_err_addr
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [DATA_W-1:0] expected_c;
  logic              mismatch_q, mismatch_d;
  logic              err_q, err_d;
  logic [15:0]       err_count_q, err_count_d;
  logic [ADDR_W-1:0] first_err_q, first_err_d;

  assign expected_c = DATA_W'(pattern_word(LANE_W'(i_addr)));

  // Next-state for the compare flag and error bookkeeping.
  always_comb begin
    mismatch_d  = mismatch_q;
    err_d       = err_q;
    err_count_d = err_count_q;
    first_err_d = first_err_q;
    if (i_clear) begin
      mismatch_d  = 1'b0;
      err_d       = 1'b0;
      err_count_d = '0;
      first_err_d = '0;
    end else begin
      if (i_sample) begin
        mismatch_d = (i_rd_data != expected_c);
      end
      if (i_apply && mismatch_q) begin
        err_d = 1'b1;
        if (err_count_q != CNT_MAX) begin
          err_count_d = err_count_q + 16'd1;
        end
        // Only the first failing word of a sweep records its address.
        if (!err_q) begin
          first_err_d = i_addr;
        end
      end
    end
  end

  // Error state registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mismatch_q  <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
      first_err_q <= '0;
    end else begin
      mismatch_q  <= mismatch_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
      first_err_q <= first_err_d;
    end
  end

  assign o_err            = err_q;
  assign o_err_count      = err_count_q;
  assign o_first_err_addr = first_err_q;

endmodule

// File: rtl/ram_reader.sv
// RAM read-back sequencer: sweeps START_ADDR..END_ADDR with one read
// outstanding at a time and checks every word against the writer pattern.
// Ports:
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   i_start            begins a sweep when idle or done
//   o_rd_en, o_rd_addr single-cycle read strobe and its address
//   i_rd_data          read data, valid RD_LATENCY cycles after o_rd_en
//   o_busy, o_done     sweep in progress / sweep complete (held)
//   o_err, o_err_count, o_first_err_addr  check results of the current sweep
module ram_reader
  import ramrw_pkg::*;
#(
  parameter int unsigned       ADDR_W     = DEF_ADDR_W,
  parameter int unsigned       DATA_W     = DEF_DATA_W,
  parameter int unsigned       RD_LATENCY = 2,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(1),
  parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(14'h2000)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [15:0]       o_err_count,
  output logic [ADDR_W-1:0] o_first_err_addr
);

  localparam int unsigned   CNT_W    = 3;
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RD_LATENCY - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              clear_c, sample_c, apply_c;

  // Next-state and control decode.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    clear_c  = 1'b0;
    sample_c = 1'b0;
    apply_c  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_d = ST_ISSUE;
          addr_d  = START_ADDR;
          clear_c = 1'b1;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Leaving WAIT on this edge lands the sample RD_LATENCY cycles after ISSUE.
        if (cnt_q == LAT_LAST) begin
          sample_c = 1'b1;
          state_d  = ST_CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CHECK: begin
        apply_c = 1'b1;
        if (addr_q == END_ADDR) begin
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered off the next state so they line up with it.
    rd_en_d = (state_d == ST_ISSUE);
    busy_d  = (state_d == ST_ISSUE) || (state_d == ST_WAIT) || (state_d == ST_CHECK);
    done_d  = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  ram_rd_checker #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_checker (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_clear         (clear_c),
    .i_sample        (sample_c),
    .i_apply         (apply_c),
    .i_addr          (addr_q),
    .i_rd_data       (i_rd_data),
    .o_err           (o_err),
    .o_err_count     (o_err_count),
    .o_first_err_addr(o_first_err_addr)
  );

  // Address register doubles as the held read address.
  assign o_rd_en   = rd_en_q;
  assign o_rd_addr = addr_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;

endmodule

// File: tb/tb_ram_reader.sv
module tb_ram_reader;

  localparam int unsigned AW    = 14;
  localparam int unsigned DW    = 64;
  localparam int          A_LAT = 2;
  localparam int          A_LO  = 1;
  localparam int          A_HI  = 8;
  localparam int          B_ADR = 'h2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start_a, start_b;
  logic          rd_en_a, rd_en_b;
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic [DW-1:0] rd_data_a, rd_data_b;
  logic          busy_a, busy_b, done_a, done_b, err_a, err_b;
  logic [15:0]   cnt_a, cnt_b;
  logic [AW-1:0] first_a, first_b;

  ram_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(A_LAT),
               .START_ADDR(14'd1), .END_ADDR(14'd8)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a),
    .o_rd_en(rd_en_a), .o_rd_addr(rd_addr_a), .i_rd_data(rd_data_a),
    .o_busy(busy_a), .o_done(done_a), .o_err(err_a),
    .o_err_count(cnt_a), .o_first_err_addr(first_a));

  ram_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1),
               .START_ADDR(14'h2000), .END_ADDR(14'h2000)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b),
    .o_rd_en(rd_en_b), .o_rd_addr(rd_addr_b), .i_rd_data(rd_data_b),
    .o_busy(busy_b), .o_done(done_b), .o_err(err_b),
    .o_err_count(cnt_b), .o_first_err_addr(first_b));

  // RAM models: data appears exactly the latency after the strobe, junk otherwise.
  logic [DW-1:0] mem_a [0:(1<<AW)-1];
  logic [DW-1:0] mem_b [0:(1<<AW)-1];
  logic [DW-1:0] pipe_a0, pipe_a1, pipe_b0;

  always @(posedge clk) begin
    pipe_a0 <= rd_en_a ? mem_a[rd_addr_a] : {$urandom(), $urandom()};
    pipe_a1 <= pipe_a0;
    pipe_b0 <= rd_en_b ? mem_b[rd_addr_b] : {$urandom(), $urandom()};
  end
  assign rd_data_a = pipe_a1;
  assign rd_data_b = pipe_b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference pattern straight from the lane rule.
  function automatic logic [63:0] exp_word(input int a);
    logic [15:0] b;
    b = 16'(a * 4);
    return {16'(b + 3), 16'(b + 2), 16'(b + 1), b};
  endfunction

  // Strobe monitor for DUT A, plus done-edge and strobe counts.
  int cyc = 0;
  int strobe_addr[$];
  int strobe_cyc[$];
  int done_rises = 0;
  logic done_prev = 1'b0;
  int strobes_b = 0;

  always @(negedge clk) begin
    cyc++;
    if (rd_en_a) begin
      strobe_addr.push_back(int'(rd_addr_a));
      strobe_cyc.push_back(cyc);
    end
    if (done_a && !done_prev) done_rises++;
    done_prev = done_a;
    if (rd_en_b) strobes_b++;
  end

  task automatic fill_clean_a();
    for (int a = 0; a < 16; a++) mem_a[a] = exp_word(a);
  endtask

  task automatic model_a(output int ecnt, output int efirst);
    ecnt = 0;
    efirst = 0;
    for (int a = A_LO; a <= A_HI; a++) begin
      if (mem_a[a] !== exp_word(a)) begin
        if (ecnt == 0) efirst = a;
        ecnt++;
      end
    end
  endtask

  task automatic wait_done_a(input string tag);
    int k = 0;
    while (!done_a && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done_reached"}, done_a, 1);
  endtask

  task automatic check_sweep_a(input string tag);
    int ecnt, efirst, n;
    model_a(ecnt, efirst);
    n = A_HI - A_LO + 1;
    chk({tag, "_nstrobe"}, strobe_addr.size(), n);
    for (int i = 0; i < strobe_addr.size() && i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), strobe_addr[i], A_LO + i);
      if (i > 0) chk($sformatf("%s_gap%0d", tag, i), strobe_cyc[i] - strobe_cyc[i-1], A_LAT + 2);
    end
    chk({tag, "_done_rises"}, done_rises, 1);
    chk({tag, "_done"}, done_a, 1);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_err"}, err_a, (ecnt != 0));
    chk({tag, "_errcnt"}, cnt_a, ecnt);
    chk({tag, "_first"}, first_a, efirst);
    chk({tag, "_rdaddr_hold"}, rd_addr_a, A_HI);
  endtask

  task automatic run_sweep_a(input string tag, input bit mid_start);
    int k;
    strobe_addr.delete();
    strobe_cyc.delete();
    done_rises = 0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk({tag, "_busy_start"}, busy_a, 1);
    chk({tag, "_done_drop"}, done_a, 0);
    chk({tag, "_rden_start"}, rd_en_a, 1);
    chk({tag, "_addr_start"}, rd_addr_a, A_LO);
    chk({tag, "_err_clr"}, err_a, 0);
    chk({tag, "_cnt_clr"}, cnt_a, 0);
    chk({tag, "_first_clr"}, first_a, 0);
    if (mid_start) begin
      k = 0;
      while (!(rd_en_a && rd_addr_a == 14'd3) && k < 100) begin
        @(negedge clk);
        k++;
      end
      chk({tag, "_third_strobe"}, rd_addr_a, 3);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
    end
    wait_done_a(tag);
    repeat (3) @(negedge clk);
    check_sweep_a(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nq;
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    fill_clean_a();
    repeat (3) @(negedge clk);
    chk("rst_rden", rd_en_a, 0);
    chk("rst_addr", rd_addr_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_first", first_a, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean sweep, then single-lane corruption, then two bad words.
    run_sweep_a("clean", 1'b0);
    mem_a[5][47:32] = 16'h0000;
    run_sweep_a("lane2_a5", 1'b0);
    fill_clean_a();
    mem_a[3] = mem_a[3] ^ 64'h1;
    mem_a[6] = mem_a[6] ^ 64'h8000_0000_0000_0000;
    run_sweep_a("two_bad", 1'b0);
    fill_clean_a();
    run_sweep_a("reclean", 1'b0);

    // Start pulse while busy must not restart.
    run_sweep_a("busy_start", 1'b1);

    // Reset in the wait of address 4.
    strobe_addr.delete();
    strobe_cyc.delete();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    k = 0;
    while (!(rd_en_a && rd_addr_a == 14'd4) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("mid_rst_reach4", rd_addr_a, 4);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_rden", rd_en_a, 0);
    chk("mid_rst_addr", rd_addr_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_done", done_a, 0);
    chk("mid_rst_err", err_a, 0);
    chk("mid_rst_cnt", cnt_a, 0);
    nq = strobe_addr.size();
    repeat (8) @(negedge clk);
    chk("mid_rst_idle_nostrobe", strobe_addr.size(), nq);
    chk("mid_rst_idle_busy", busy_a, 0);
    mem_a[2] = 64'h0;
    run_sweep_a("after_rst", 1'b0);

    // Randomised corruption, including addresses outside the sweep.
    for (int t = 0; t < 6; t++) begin
      fill_clean_a();
      for (int a = 0; a < 10; a++) begin
        if ($urandom_range(0, 2) == 0) mem_a[a] = mem_a[a] ^ (64'h1 << $urandom_range(0, 63));
      end
      run_sweep_a($sformatf("rand%0d", t), 1'b0);
    end

    // Single-address sweep at the top of range with latency 1.
    mem_b[B_ADR] = exp_word(B_ADR);
    strobes_b = 0;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("b_rden", rd_en_b, 1);
    chk("b_addr", rd_addr_b, B_ADR);
    k = 0;
    while (!done_b && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("b_done", done_b, 1);
    chk("b_nstrobe", strobes_b, 1);
    chk("b_err", err_b, 0);
    chk("b_cnt", cnt_b, 0);
    chk("b_first", first_b, 0);
    mem_b[B_ADR][63:48] = 16'h0000;
    strobes_b = 0;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    k = 0;
    while (!done_b && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("b2_done", done_b, 1);
    chk("b2_nstrobe", strobes_b, 1);
    chk("b2_err", err_b, 1);
    chk("b2_cnt", cnt_b, 1);
    chk("b2_first", first_b, B_ADR);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
